// File: rtl/crc_byte_serializer.sv
// Byte-to-serial feeder for the serial CRC engine: buffers parallel bytes in a
// small FIFO and shifts each out LSB-first with ACTIVE framing and an inter-frame gap.
module crc_byte_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned GAP_CYCLES = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  output logic                  SER_DATA,
  output logic                  ACTIVE,
  output logic                  BUSY
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] shreg;
  logic [AW:0]           wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]         bit_cnt;
  logic [GW-1:0]         gap_cnt;
  logic                  ready_en;
  logic                  full, empty, empty_nxt;
  logic                  push, pop, bit_done, gap_done;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  always_comb begin
    full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    empty      = (wr_ptr == rd_ptr);
    DATA_READY = ready_en && !full;
    push       = DATA_VALID && DATA_READY;
    bit_done   = (bit_cnt == BIT_LAST);
    gap_done   = (gap_cnt == GAP_LAST);
    pop        = !empty && ((state == IDLE) || ((state == GAP) && gap_done));
    wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
    rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
    empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
    head       = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= P_DATA;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ready_en <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      ready_en <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      SER_DATA <= 1'b0;
      ACTIVE   <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= SHIFT;
            shreg    <= head;
            SER_DATA <= head[0];
            ACTIVE   <= 1'b1;
            bit_cnt  <= '0;
            BUSY     <= 1'b1;
          end else begin
            SER_DATA <= 1'b0;
            ACTIVE   <= 1'b0;
            BUSY     <= !empty_nxt;
          end
        end
        SHIFT: begin
          BUSY <= 1'b1;
          if (bit_done) begin
            state    <= GAP;
            SER_DATA <= 1'b0;
            ACTIVE   <= 1'b0;
            gap_cnt  <= '0;
          end else begin
            shreg    <= shreg >> 1;
            SER_DATA <= shreg[1];
            bit_cnt  <= bit_cnt + 1'b1;
          end
        end
        GAP: begin
          if (!gap_done) begin
            gap_cnt <= gap_cnt + 1'b1;
            BUSY    <= 1'b1;
          end else if (pop) begin
            // Back-to-back frame: start shifting without passing through IDLE.
            state    <= SHIFT;
            shreg    <= head;
            SER_DATA <= head[0];
            ACTIVE   <= 1'b1;
            bit_cnt  <= '0;
            BUSY     <= 1'b1;
          end else begin
            state <= IDLE;
            BUSY  <= !empty_nxt;
          end
        end
        default: begin
          state    <= IDLE;
          SER_DATA <= 1'b0;
          ACTIVE   <= 1'b0;
          BUSY     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_byte_serializer.sv
// Scoreboard bench for crc_byte_serializer: expected bytes are queued when driven and
// compared against frames reassembled from SER_DATA/ACTIVE.
module tb_crc_byte_serializer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       DATA_VALID = 1'b0;
  logic       DATA_READY, SER_DATA, ACTIVE, BUSY;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int         frames_seen = 0;
  int         last_gap = 0;
  bit         in_frame = 0;
  int         nbits = 0;
  int         low_run = 0;
  logic [7:0] byte_acc = '0;

  crc_byte_serializer #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(2),
    .GAP_CYCLES(10)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID),
    .DATA_READY(DATA_READY),
    .SER_DATA(SER_DATA),
    .ACTIVE(ACTIVE),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame monitor: reassembles each ACTIVE burst and checks it against the scoreboard.
  always @(negedge CLK) begin
    if (!RST) begin
      in_frame = 0;
      nbits    = 0;
      low_run  = 0;
    end else if (ACTIVE) begin
      if (!in_frame) begin
        in_frame = 1;
        nbits    = 0;
        byte_acc = '0;
        last_gap = low_run;
      end
      if (nbits < 8) byte_acc[nbits] = SER_DATA;
      nbits++;
    end else if (in_frame) begin
      in_frame = 0;
      chk("frame_len", nbits, 8);
      chk("ser_idle", SER_DATA, 1'b0);
      chk("frame_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("frame_byte", byte_acc, exp_q.pop_front());
      frames_seen++;
      low_run = 1;
    end else begin
      low_run++;
    end
  end

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while ((BUSY || in_frame || exp_q.size() != 0) && n < max_cycles) begin
      @(negedge CLK);
      n++;
    end
    chk("idle_in_time", n < max_cycles, 1);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge CLK);
    while (!DATA_READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("ready_in_time", n < 100, 1);
    P_DATA     = b;
    DATA_VALID = 1'b1;
    exp_q.push_back(b);
    @(negedge CLK);
    DATA_VALID = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vals [4];
    logic       rdy_exp [4];
    int         fs, act_cnt;
    vals    = '{8'h11, 8'h22, 8'h33, 8'h44};
    rdy_exp = '{1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_ready", DATA_READY, 0);
    chk("rst_active", ACTIVE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_ser", SER_DATA, 0);
    RST = 1'b1;
    #1 chk("ready_pre_edge", DATA_READY, 0);
    @(negedge CLK);
    chk("ready_after_rel", DATA_READY, 1);
    chk("active_after_rel", ACTIVE, 0);
    chk("busy_after_rel", BUSY, 0);

    // Single byte with latency and gap-end timing
    P_DATA = 8'hA5; DATA_VALID = 1'b1; exp_q.push_back(8'hA5);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    chk("lat_pre", ACTIVE, 0);
    chk("busy_after_write", BUSY, 1);
    @(negedge CLK);
    chk("lat_first", ACTIVE, 1);
    chk("lat_bit0", SER_DATA, 1);
    repeat (17) @(negedge CLK);
    chk("busy_gap_end", BUSY, 1);
    @(negedge CLK);
    chk("busy_idle", BUSY, 0);
    chk("single_frames", frames_seen, 1);
    wait_idle(50);

    // Back-to-back frames
    @(negedge CLK);
    P_DATA = 8'h01; DATA_VALID = 1'b1; exp_q.push_back(8'h01);
    @(negedge CLK);
    chk("b2b_ready0", DATA_READY, 1);
    P_DATA = 8'hFF; exp_q.push_back(8'hFF);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    chk("b2b_ready1", DATA_READY, 1);
    wait_idle(100);
    chk("b2b_gap", last_gap, 10);
    chk("b2b_frames", frames_seen, 3);

    // FIFO full: fourth byte dropped
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk($sformatf("full_ready%0d", i), DATA_READY, rdy_exp[i]);
      P_DATA = vals[i]; DATA_VALID = 1'b1;
    end
    @(negedge CLK);
    DATA_VALID = 1'b0;
    chk("full_still", DATA_READY, 0);
    wait_idle(200);
    chk("full_frames", frames_seen, 6);

    // Reset mid-frame discards the frame and the queued byte
    @(negedge CLK);
    P_DATA = 8'h3C; DATA_VALID = 1'b1;
    @(negedge CLK);
    P_DATA = 8'h55;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    chk("abort_bit4", SER_DATA, 1);
    #2 RST = 1'b0;
    #1;
    chk("abort_active", ACTIVE, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_ser", SER_DATA, 0);
    chk("abort_ready", DATA_READY, 0);
    P_DATA = 8'h77; DATA_VALID = 1'b1;
    repeat (2) @(negedge CLK);
    DATA_VALID = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_ready_rel", DATA_READY, 1);
    chk("abort_busy_rel", BUSY, 0);
    fs = frames_seen;
    act_cnt = 0;
    repeat (40) begin
      @(negedge CLK);
      if (ACTIVE) act_cnt++;
    end
    chk("abort_no_active", act_cnt, 0);
    chk("abort_frames", frames_seen, fs);

    // Random bytes with random spacing
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 12)) @(negedge CLK);
    end
    wait_idle(400);
    chk("rand_frames", frames_seen, fs + 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
